// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and counter sizing.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Counter must hold the value WIDTH, hence WIDTH+1 codes.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Control unit for the shift-and-add multiplier: sequencing FSM, cycle counter,
// registered busy/done, and the load/step/finish/clear strobes for the datapath.
module shift_add_mult_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   output logic load,
   output logic step,
   output logic finish,
   output logic clear,
   output logic busy,
   output logic done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // Next-state, counter and strobe decode; abort outranks the FIN update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               clear   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_FIN: begin
            if (abort) begin
               clear = 1'b1;
            end else begin
               finish = 1'b1;
            end
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = finish;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Operands are multiplied as magnitudes; the sign is reapplied when the result is stored.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;

   // The most-negative value maps to 2^(W-1), which still fits in W unsigned bits.
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sm);
      if (sm && v[WIDTH-1]) begin
         return (~v) + WIDTH'(1);
      end else begin
         return v;
      end
   endfunction

   logic load_s, step_s, finish_s, clear_s;

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    product_q, product_d;

   shift_add_mult_ctrl #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .abort  (abort),
      .load   (load_s),
      .step   (step_s),
      .finish (finish_s),
      .clear  (clear_s),
      .busy   (busy),
      .done   (done)
   );

   // Datapath next-state driven by the control strobes.
   always_comb begin
      mcand_d   = mcand_q;
      mag_b_d   = mag_b_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      product_d = product_q;
      if (load_s) begin
         mcand_d = {{WIDTH{1'b0}}, mag_of(op_a, signed_mode)};
         mag_b_d = mag_of(op_b, signed_mode);
         neg_d   = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         acc_d   = '0;
      end else if (step_s) begin
         if (mag_b_q[0]) begin
            acc_d = acc_q + mcand_q;
         end else begin
            acc_d = acc_q;
         end
         mcand_d = mcand_q << 1;
         mag_b_d = mag_b_q >> 1;
      end else if (finish_s) begin
         if (neg_q) begin
            product_d = (~acc_q) + PW'(1);
         end else begin
            product_d = acc_q;
         end
      end else if (clear_s) begin
         mcand_d = '0;
         mag_b_d = '0;
         acc_d   = '0;
         neg_d   = 1'b0;
      end else begin
         product_d = product_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mag_b_q   <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mag_b_q   <= mag_b_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at WIDTH=4 and WIDTH=8, with hand-computed products.
module tb_shift_add_mult;

   logic       clk;
   logic       rst_n;
   logic       start, signed_mode, abort;
   logic [3:0] op_a, op_b;
   logic       busy, done;
   logic [7:0] product;

   logic        start8, signed_mode8, abort8;
   logic [7:0]  op_a8, op_b8;
   logic        busy8, done8;
   logic [15:0] product8;

   int n_pass   = 0;
   int n_checks = 0;

   shift_add_mult #(.WIDTH(4)) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .signed_mode (signed_mode),
      .op_a (op_a), .op_b (op_b), .abort (abort),
      .busy (busy), .done (done), .product (product)
   );

   shift_add_mult #(.WIDTH(8)) dut8 (
      .clk (clk), .rst_n (rst_n), .start (start8), .signed_mode (signed_mode8),
      .op_a (op_a8), .op_b (op_b8), .abort (abort8),
      .busy (busy8), .done (done8), .product (product8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance negedges until done is seen or the budget runs out.
   task automatic wait_done4(inout int edges);
      while (done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      input logic [7:0] exp, input string tag);
      int edges;
      @(negedge clk);
      chk({tag, "_idle_at_start"}, 32'(busy), 32'd0);
      op_a = a; op_b = b; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0; edges = 1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done4(edges);
      chk({tag, "_latency"}, 32'(edges), 32'd6);
      chk({tag, "_product"}, 32'(product), 32'(exp));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(done), 32'd0);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input string tag);
      int edges;
      @(negedge clk);
      op_a8 = a; op_b8 = b; signed_mode8 = sm; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; edges = 1;
      while (done8 !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk({tag, "_latency"}, 32'(edges), 32'd10);
      chk({tag, "_product"}, 32'(product8), 32'(exp));
   endtask

   initial begin
      int edges;
      logic seen_done;
      logic [3:0] ra, rb;
      logic rs;
      logic [7:0] rexp;
      logic signed [7:0] sa, sb;

      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; abort = 1'b0;
      op_a = 4'd0; op_b = 4'd0;
      start8 = 1'b0; signed_mode8 = 1'b0; abort8 = 1'b0;
      op_a8 = 8'd0; op_b8 = 8'd0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op4(4'hF, 4'hF, 1'b0, 8'hE1, "u15x15");
      op4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
      op4(4'h8, 4'h7, 1'b1, 8'hC8, "s_m8x7");
      op4(4'h7, 4'hF, 1'b1, 8'hF9, "s_7xm1");
      op4(4'hF, 4'h1, 1'b1, 8'hFF, "s_m1x1");
      op4(4'h0, 4'h9, 1'b0, 8'h00, "zero_a");

      // Unsigned 8*15 with operand changes and a stray start while busy.
      @(negedge clk);
      op_a = 4'h8; op_b = 4'hF; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op_a = 4'h3; op_b = 4'h3; edges = 1;
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; edges++;
      @(negedge clk);
      start = 1'b0; edges++;
      wait_done4(edges);
      chk("ignored_start_latency", 32'(edges), 32'd6);
      chk("ignored_start_product", 32'(product), 32'h78);

      op4(4'hF, 4'hF, 1'b0, 8'hE1, "u15x15_again");

      // Abort raised after E3 and sampled at E4 of 9*9.
      @(negedge clk);
      op_a = 4'h9; op_b = 4'h9; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      seen_done = done;
      repeat (8) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      chk("abort_product_kept", 32'(product), 32'hE1);

      // Abort in IDLE does nothing.
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'd0);
      chk("idle_abort_product", 32'(product), 32'hE1);

      // Start and abort together in IDLE: start wins.
      @(negedge clk);
      op_a = 4'h3; op_b = 4'h3; signed_mode = 1'b0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; edges = 1;
      chk("start_abort_busy", 32'(busy), 32'd1);
      wait_done4(edges);
      chk("start_abort_latency", 32'(edges), 32'd6);
      chk("start_abort_product", 32'(product), 32'h09);

      // Async reset in the middle of a run.
      @(negedge clk);
      op_a = 4'hD; op_b = 4'hB; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_busy", 32'(busy), 32'd0);
      chk("midrun_reset_done", 32'(done), 32'd0);
      chk("midrun_reset_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op4(4'h3, 4'h5, 1'b0, 8'h0F, "after_reset_3x5");

      // Back-to-back with start held: second op is accepted in the done cycle.
      @(negedge clk);
      op_a = 4'h2; op_b = 4'h3; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      op_a = 4'h4; op_b = 4'h4; edges = 1;
      wait_done4(edges);
      chk("b2b_first_latency", 32'(edges), 32'd6);
      chk("b2b_first_product", 32'(product), 32'h06);
      @(negedge clk);
      start = 1'b0; edges = 1;
      chk("b2b_done_drops", 32'(done), 32'd0);
      chk("b2b_second_busy", 32'(busy), 32'd1);
      wait_done4(edges);
      chk("b2b_gap", 32'(edges), 32'd6);
      chk("b2b_second_product", 32'(product), 32'h10);

      // Random operands against an independent integer model.
      for (int i = 0; i < 12; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rs = 1'($urandom_range(0, 1));
         if (rs) begin
            sa = {{4{ra[3]}}, ra};
            sb = {{4{rb[3]}}, rb};
            rexp = 8'(sa * sb);
         end else begin
            rexp = 8'({4'd0, ra} * {4'd0, rb});
         end
         op4(ra, rb, rs, rexp, "random");
      end

      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u255x255");
      op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_s_m128xm128");
      op8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_s_m128x127");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
